// File: rtl/regfile_psr_if.sv
// regfile_psr_if: operand read, result write and flag bus between the ALU side and regfile_psr
interface regfile_psr_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          flag_we;
    logic [4:0]    CLFZN_in;
    logic [4:0]    CLFZN;
    logic          carry;

    modport master (
        output ra_addr, rb_addr, wr_en, wr_addr, wr_data, flag_we, CLFZN_in,
        input  A, B, CLFZN, carry
    );

    modport slave (
        input  ra_addr, rb_addr, wr_en, wr_addr, wr_data, flag_we, CLFZN_in,
        output A, B, CLFZN, carry
    );
endinterface

// File: rtl/regfile_psr.sv
// regfile_psr: NREGS x DW register file (2 comb reads, 1 sync write) plus 5-bit CLFZN PSR; define RF_BYPASS_EN for write-through reads
module regfile_psr #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    regfile_psr_if.slave  bus
);
    localparam logic [AW:0] NR = (AW+1)'(NREGS);

    logic [DW-1:0] mem [NREGS];
    logic [4:0]    psr;
    logic [DW-1:0] a_st;
    logic [DW-1:0] b_st;
    logic          wr_ok;

    assign wr_ok = bus.wr_en && !reset && ({1'b0, bus.wr_addr} < NR);

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        // clear on reset, otherwise load when this register is the write target
        always_ff @(posedge clk)
            if (reset) mem[i] <= '0;
            else if (wr_ok && bus.wr_addr == AW'(i)) mem[i] <= bus.wr_data;
    end

    // stored-value read mux; addresses beyond NREGS match nothing and read 0
    always_comb begin
        a_st = '0;
        b_st = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (bus.ra_addr == AW'(k)) a_st = mem[k];
            if (bus.rb_addr == AW'(k)) b_st = mem[k];
        end
    end

`ifdef RF_BYPASS_EN
    assign bus.A = (wr_ok && bus.ra_addr == bus.wr_addr) ? bus.wr_data : a_st;
    assign bus.B = (wr_ok && bus.rb_addr == bus.wr_addr) ? bus.wr_data : b_st;
`else
    assign bus.A = a_st;
    assign bus.B = b_st;
`endif

    // PSR loads the ALU flags on flag_we; reset wins over the load
    always_ff @(posedge clk)
        if (reset) psr <= '0;
        else if (bus.flag_we) psr <= bus.CLFZN_in;

    assign bus.CLFZN = psr;
    assign bus.carry = psr[4];
endmodule

// File: tb/tb_regfile_psr.sv
// tb_regfile_psr: scoreboard bench for regfile_psr; expectations from a behavioural model, compared mid-cycle
module tb_regfile_psr;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_psr_if #(.AW(4), .DW(16)) bus ();

    regfile_psr #(.NREGS(16), .AW(4), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  f;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [16];
    logic [4:0]  mpsr;
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive one cycle of stimulus, push the expected combinational view, then advance the model at the edge
    task automatic step(input string tag, input logic rs, input logic we, input logic [3:0] wa,
                        input logic [15:0] wd, input logic fwe, input logic [4:0] fin,
                        input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        @(negedge clk);
        reset        = rs;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.flag_we  = fwe;
        bus.CLFZN_in = fin;
        bus.ra_addr  = ra;
        bus.rb_addr  = rb;
        e.tag = tag;
        e.a   = model[ra];
        e.b   = model[rb];
        e.f   = mpsr;
`ifdef RF_BYPASS_EN
        if (we && !rs && ra == wa) e.a = wd;
        if (we && !rs && rb == wa) e.b = wd;
`endif
        q.push_back(e);
        @(posedge clk);
        if (rs) begin
            foreach (model[k]) model[k] = '0;
            mpsr = '0;
        end else begin
            if (we) model[wa] = wd;
            if (fwe) mpsr = fin;
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] ra, input logic [3:0] rb);
        step(tag, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 5'b0, ra, rb);
    endtask

    // monitor: pop one expectation per cycle that has stimulus and compare the live outputs
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, ":A"}, bus.A, e.a);
                check({e.tag, ":B"}, bus.B, e.b);
                check({e.tag, ":CLFZN"}, {11'b0, bus.CLFZN}, {11'b0, e.f});
                check({e.tag, ":carry"}, {15'b0, bus.carry}, {15'b0, e.f[4]});
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.flag_we  = 1'b0;
        bus.CLFZN_in = '0;
        bus.ra_addr  = '0;
        bus.rb_addr  = '0;
        foreach (model[k]) model[k] = '0;
        mpsr = '0;
        @(posedge clk);

        step("rst_hold", 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 5'b0, 4'd0, 4'd15);
        step("w_beef", 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 5'b0, 4'd3, 4'd3);
        step("rst_mid", 1'b1, 1'b1, 4'd3, 16'h1234, 1'b1, 5'b11111, 4'd3, 4'd3);
        rd("after_rst", 4'd3, 4'd3);

        for (int i = 0; i < 16; i++)
            step("wall", 1'b0, 1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, 5'b0, 4'(i), 4'(15 - i));
        for (int i = 0; i < 16; i++)
            rd("sweep", 4'(i), 4'(15 - i));

        step("r5_pre", 1'b0, 1'b1, 4'd5, 16'h00AA, 1'b0, 5'b0, 4'd0, 4'd1);
        step("hazard", 1'b0, 1'b1, 4'd5, 16'h5555, 1'b0, 5'b0, 4'd5, 4'd5);
        rd("hazard_next", 4'd5, 4'd5);

        step("psr_load", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 5'b10010, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++)
            step("psr_hold", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 5'b00000, 4'd0, 4'd0);
        rd("psr_after", 4'd0, 4'd0);

        step("psr_clr", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 5'b00000, 4'd0, 4'd0);
        step("r1", 1'b0, 1'b1, 4'd1, 16'hFFFF, 1'b0, 5'b0, 4'd1, 4'd2);
        step("r2", 1'b0, 1'b1, 4'd2, 16'h0001, 1'b0, 5'b0, 4'd1, 4'd2);
        step("addu", 1'b0, 1'b1, 4'd3, 16'h0000, 1'b1, 5'b10010, 4'd1, 4'd2);
        rd("addc", 4'd1, 4'd2);

        step("simul", 1'b0, 1'b1, 4'd7, 16'h7777, 1'b1, 5'b00100, 4'd7, 4'd0);
        for (int i = 0; i < 16; i++)
            rd("post_simul", 4'(i), 4'(i ^ 7));

        for (int i = 0; i < 40; i++)
            step("rand", $urandom_range(0, 15) == 0, 1'($urandom), 4'($urandom), 16'($urandom),
                 1'($urandom), 5'($urandom), 4'($urandom), 4'($urandom));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain", 16'(q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/regfile_psr.md
# regfile_psr

Architectural register file and processor status register (PSR) for the 16-bit datapath. Two combinational read ports drive the ALU operand inputs A and B, and one synchronous write port accepts the ALU result S. A 5-bit PSR captures the ALU's CLFZN flag vector and feeds the stored carry back for add-with-carry operations. The block sits directly upstream of the ALU as its operand source and directly downstream of it as its result and flag sink.

## Interface
Parameters:
- NREGS, 16: number of general registers (power of two, 2..16).
- AW, 4: register address width (log2(NREGS)).
- DW, 16: data width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all registers and the PSR.
- ra_addr  in  AW  read port A address.
- rb_addr  in  AW  read port B address.
- A  out  DW  contents of register ra_addr, to the ALU A input.
- B  out  DW  contents of register rb_addr, to the ALU B input.
- wr_en  in  1  register write strobe.
- wr_addr  in  AW  destination register.
- wr_data  in  DW  write data (ALU S).
- flag_we  in  1  PSR load strobe.
- CLFZN_in  in  5  flag vector from the ALU; bit 4 C, bit 3 L, bit 2 F, bit 1 Z, bit 0 N.
- CLFZN  out  5  current PSR contents.
- carry  out  1  equals CLFZN[4]; the carry-in for ADDC, ADDCI, ADDCU and ADDCUI.

## Operation
- Storage: NREGS x DW flops plus a 5-bit PSR. No register is hardwired; r0 is writable.
- Write: on a rising clk edge with wr_en=1 and reset=0, reg[wr_addr] <= wr_data. All other registers hold.
- Read: A = reg[ra_addr] and B = reg[rb_addr], purely combinational from addresses and stored state. Both ports may address the same register.
- PSR: on a rising edge with flag_we=1 and reset=0, PSR <= CLFZN_in. With flag_we=0 the PSR holds.
- Independence: the write port and the PSR load are independent. Any combination of wr_en and flag_we is legal in the same cycle.
- Address range: when NREGS < 2^AW, writes to addresses >= NREGS are dropped and reads from them return 0.
- Reset: while reset=1 at an edge, all registers and the PSR are cleared to 0. This overrides wr_en and flag_we in the same cycle. After reset, A, B and CLFZN read 0 and carry=0.
- Reset mid-operation: any write or flag load presented in a reset cycle is lost. Nothing is deferred.

## Timing
- Write latency: 1 cycle. Data written at edge n is visible on A/B after edge n, through combinational read.
- PSR latency: 1 cycle. The carry produced by instruction i is available as carry-in to instruction i+1.
- Same-cycle read of a register being written: the result depends on RF_BYPASS_EN (see Configuration).
- The PSR has no bypass. carry always reflects the stored PSR, never CLFZN_in.
- Outputs A, B, CLFZN and carry carry no registered stage beyond the storage itself.

## Configuration
- Macro RF_BYPASS_EN.
- Defined: write-through is active. If wr_en=1, reset=0 and ra_addr==wr_addr, then A=wr_data in that same cycle; the same rule applies to B with rb_addr. The register is still written at the edge.
- Not defined: A and B return the pre-write stored value during the write cycle. The new value appears only after the edge.
- The bypass never applies while reset=1, and it does not apply to the PSR.

## Test plan
- Reset clear: write 0xBEEF to r3, then assert reset for 1 cycle with wr_en=1, wr_addr=3, wr_data=0x1234 and flag_we=1 -> r3=0, A(ra_addr=3)=0, CLFZN=5'b00000, carry=0.
- Write/read all registers: write reg[i]=0x1000+i for i=0..15, then sweep ra_addr and rb_addr in opposite orders -> A=0x1000+ra_addr and B=0x1000+rb_addr every cycle, with no aliasing.
- Same-cycle hazard: with r5=0x00AA, drive wr_en=1, wr_addr=5, wr_data=0x5555 and ra_addr=rb_addr=5 -> A=B=0x5555 in that cycle with RF_BYPASS_EN defined, A=B=0x00AA without it; both configurations show 0x5555 on the next cycle.
- PSR hold/load: flag_we=1 with CLFZN_in=5'b10010 -> CLFZN=5'b10010 and carry=1 next cycle. Then flag_we=0 with CLFZN_in=5'b00000 for 3 cycles -> the PSR stays 5'b10010.
- Carry chain: load r1=0xFFFF and r2=0x0001; ALU ADDU writes S=0x0000 to r3 with flag_we=1 -> carry=1, CLFZN[1]=1. The next ADDC of r1+r2 then sees carry=1 on its carry input.
- Simultaneous ports: in one cycle drive wr_en=1 (r7<=0x7777) and flag_we=1 (CLFZN_in=5'b00100) -> both are committed at the same edge, and all other registers are unchanged.
